// File: rtl/rom_dl_pkg.sv
// Shared constants and types for the ROM download router.
package rom_dl_pkg;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } dl_state_e;

endpackage

// File: rtl/rom_dl_rstseq.sv
// Post-download core reset sequencer: remembers that a ROM has loaded and
// holds the game core in reset for RST_CYCLES after the last reset cause.
module rom_dl_rstseq #(
  parameter logic [15:0] RST_CYCLES = 16'hFFFF
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic rom_dl,
  input  logic user_reset,
  output logic rom_loaded,
  output logic core_reset
);

  logic        rom_dl_q, rom_dl_d;
  logic        rom_loaded_q, rom_loaded_d;
  logic [15:0] cnt_q, cnt_d;
  logic        core_reset_q, core_reset_d;

  // Detect end of ROM download, reload or run down the hold counter.
  always_comb begin
    rom_dl_d     = rom_dl;
    rom_loaded_d = rom_loaded_q | (rom_dl_q & ~rom_dl);
    if (user_reset | ~rom_loaded_q | rom_dl) begin
      cnt_d = RST_CYCLES;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
    core_reset_d = (cnt_q != 16'd0);
  end

  // Sequencer registers; reset keeps the core held.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rom_dl_q     <= 1'b0;
      rom_loaded_q <= 1'b0;
      cnt_q        <= RST_CYCLES;
      core_reset_q <= 1'b1;
    end else begin
      rom_dl_q     <= rom_dl_d;
      rom_loaded_q <= rom_loaded_d;
      cnt_q        <= cnt_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign rom_loaded = rom_loaded_q;
  assign core_reset = core_reset_q;

endmodule

// File: rtl/rom_dl_router.sv
// ROM download router: decodes hps_io byte writes against NREG windows,
// drives toggle-handshake or BRAM-pulse write strobes, captures core_mod
// and DIP bytes, and sequences the core reset after download.
module rom_dl_router
  import rom_dl_pkg::*;
#(
  parameter int                 NREG        = 4,
  parameter int                 AW          = 25,
  parameter logic [NREG*AW-1:0] REG_BASE    = {NREG{{AW{1'b0}}}},
  parameter logic [NREG*AW-1:0] REG_END     = {NREG{{AW{1'b1}}}},
  parameter logic [NREG-1:0]    REG_NOACK   = {NREG{1'b0}},
  parameter int                 ACK_TIMEOUT = 1023,
  parameter logic [15:0]        RST_CYCLES  = 16'hFFFF,
  parameter int                 DIP_BYTES   = 8
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [AW-1:0]          ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  output logic                   ioctl_wait,
  input  logic                   user_reset,
  output logic [AW-1:0]          wr_addr,
  output logic [15:0]            wr_data,
  output logic [1:0]             wr_be,
  output logic [NREG-1:0]        reg_req,
  input  logic [NREG-1:0]        reg_ack,
  output logic [NREG-1:0]        reg_we,
  output logic [7:0]             core_mod,
  output logic [8*DIP_BYTES-1:0] dip_sw,
  output logic                   rom_loaded,
  output logic                   core_reset,
  output logic                   dl_err
);

  localparam int TW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT);

  dl_state_e state_q, state_d;

  logic [NREG-1:0]        req_q, req_d;
  logic [NREG-1:0]        we_q, we_d;
  logic [NREG-1:0]        pend_q, pend_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [AW-1:0]          wr_addr_q, wr_addr_d;
  logic [15:0]            wr_data_q, wr_data_d;
  logic [1:0]             wr_be_q, wr_be_d;
  logic                   err_q, err_d;
  logic [7:0]             mod_q, mod_d;
  logic [8*DIP_BYTES-1:0] dip_q, dip_d;

  logic                   rom_wr;
  logic                   rom_dl;
  logic                   mod_wr;
  logic                   dip_wr;
  logic [NREG-1:0]        hit;
  logic [NREG-1:0]        ack_hit;
  logic [NREG-1:0]        noack_hit;
  logic [NREG-1:0]        pend_left;
  logic [AW-1:0]          hit_addr;

  // Window decode; the highest-numbered hit window supplies the relative address.
  always_comb begin
    rom_dl   = ioctl_download & (ioctl_index == IDX_ROM);
    rom_wr   = ioctl_wr & rom_dl;
    mod_wr   = ioctl_wr & ioctl_download & (ioctl_index == IDX_MOD);
    dip_wr   = ioctl_wr & ioctl_download & (ioctl_index == IDX_DIP);
    hit      = '0;
    hit_addr = ioctl_addr;
    for (int i = 0; i < NREG; i++) begin
      if ((ioctl_addr >= REG_BASE[i*AW +: AW]) && (ioctl_addr <= REG_END[i*AW +: AW])) begin
        hit[i]   = 1'b1;
        hit_addr = ioctl_addr - REG_BASE[i*AW +: AW];
      end
    end
    ack_hit   = hit & ~REG_NOACK;
    noack_hit = hit & REG_NOACK;
    pend_left = pend_q & (reg_ack ^ req_q);
  end

  // Handshake FSM state register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake FSM next state: wait only while a handshake window is outstanding.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rom_wr && (ack_hit != '0)) state_d = ST_WAIT;
      ST_WAIT: if ((pend_left == '0) || (timer_q == TMAX)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake FSM output: back-pressure drops as soon as the last ack lands.
  always_comb begin
    ioctl_wait = (state_q == ST_WAIT) && (pend_left != '0);
  end

  // Write latch, request toggles, ack timer, error flag and byte capture.
  always_comb begin
    req_d     = req_q;
    we_d      = '0;
    pend_d    = pend_q;
    timer_d   = timer_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_be_d   = wr_be_q;
    err_d     = err_q;
    mod_d     = mod_q;
    dip_d     = dip_q;
    if (state_q == ST_IDLE) begin
      if (rom_wr) begin
        if (hit != '0) wr_addr_d = hit_addr;
        wr_data_d = {ioctl_dout, ioctl_dout};
        wr_be_d   = {ioctl_addr[0], ~ioctl_addr[0]};
        req_d     = req_q ^ ack_hit;
        we_d      = noack_hit;
        pend_d    = ack_hit;
        timer_d   = '0;
      end
    end else begin
      pend_d = pend_left;
      if (rom_wr) err_d = 1'b1;
      if (pend_left != '0) begin
        if (timer_q == TMAX) begin
          err_d  = 1'b1;
          pend_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
    end
    if (mod_wr) mod_d = ioctl_dout;
    for (int k = 0; k < DIP_BYTES; k++) begin
      if (dip_wr && (ioctl_addr == AW'(k))) dip_d[8*k +: 8] = ioctl_dout;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      req_q     <= '0;
      we_q      <= '0;
      pend_q    <= '0;
      timer_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
      err_q     <= 1'b0;
      mod_q     <= '0;
      dip_q     <= '0;
    end else begin
      req_q     <= req_d;
      we_q      <= we_d;
      pend_q    <= pend_d;
      timer_q   <= timer_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_be_q   <= wr_be_d;
      err_q     <= err_d;
      mod_q     <= mod_d;
      dip_q     <= dip_d;
    end
  end

  rom_dl_rstseq #(
    .RST_CYCLES(RST_CYCLES)
  ) u_rstseq (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .rom_dl     (rom_dl),
    .user_reset (user_reset),
    .rom_loaded (rom_loaded),
    .core_reset (core_reset)
  );

  assign reg_req  = req_q;
  assign reg_we   = we_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_be    = wr_be_q;
  assign dl_err   = err_q;
  assign core_mod = mod_q;
  assign dip_sw   = dip_q;

endmodule

// File: tb/tb_rom_dl_router.sv
// Bench for rom_dl_router: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_rom_dl_router;

  localparam int          NREG        = 4;
  localparam int          AW          = 25;
  localparam int          ACK_TIMEOUT = 15;
  localparam logic [15:0] RST_CYCLES  = 16'd16;
  localparam int          DIP_BYTES   = 8;
  localparam logic [NREG*AW-1:0] REG_BASE = {25'h80000, 25'h20000, 25'h30000, 25'h28000};
  localparam logic [NREG*AW-1:0] REG_END  = {25'h8FFFF, 25'h27FFF, 25'h8FFFF, 25'h3FFFF};
  localparam logic [NREG-1:0]    REG_NOACK = 4'b1100;

  // Windows as the bench understands them: [lo, hi] inclusive, noack = BRAM.
  int unsigned win_lo[NREG]    = '{32'h28000, 32'h30000, 32'h20000, 32'h80000};
  int unsigned win_hi[NREG]    = '{32'h3FFFF, 32'h8FFFF, 32'h27FFF, 32'h8FFFF};
  bit          win_noack[NREG] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [AW-1:0] bounds[12] = '{25'h1FFFF, 25'h20000, 25'h27FFF, 25'h28000, 25'h2FFFF, 25'h30000,
                                25'h3FFFF, 25'h40000, 25'h7FFFF, 25'h80000, 25'h8FFFF, 25'h90000};

  logic                   clk_sys = 1'b0;
  logic                   reset = 1'b1;
  logic                   ioctl_download = 1'b0;
  logic [7:0]             ioctl_index = 8'd0;
  logic                   ioctl_wr = 1'b0;
  logic [AW-1:0]          ioctl_addr = '0;
  logic [7:0]             ioctl_dout = 8'd0;
  logic                   ioctl_wait;
  logic                   user_reset = 1'b0;
  logic [AW-1:0]          wr_addr;
  logic [15:0]            wr_data;
  logic [1:0]             wr_be;
  logic [NREG-1:0]        reg_req;
  logic [NREG-1:0]        reg_ack = '0;
  logic [NREG-1:0]        reg_we;
  logic [7:0]             core_mod;
  logic [8*DIP_BYTES-1:0] dip_sw;
  logic                   rom_loaded;
  logic                   core_reset;
  logic                   dl_err;

  int check_count = 0;
  int error_count = 0;

  rom_dl_router #(
    .NREG(NREG), .AW(AW), .REG_BASE(REG_BASE), .REG_END(REG_END), .REG_NOACK(REG_NOACK),
    .ACK_TIMEOUT(ACK_TIMEOUT), .RST_CYCLES(RST_CYCLES), .DIP_BYTES(DIP_BYTES)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .user_reset(user_reset), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .reg_req(reg_req), .reg_ack(reg_ack), .reg_we(reg_we), .core_mod(core_mod), .dip_sw(dip_sw),
    .rom_loaded(rom_loaded), .core_reset(core_reset), .dl_err(dl_err)
  );

  always #5 clk_sys = ~clk_sys;

  // Downstream SDRAM stand-in: echoes each req toggle after ack_lat cycles unless held.
  logic [NREG-1:0] hold_mask = '0;
  int              ack_lat = 0;
  int              dcnt[NREG];
  always @(posedge clk_sys) begin
    if (reset) begin
      reg_ack <= '0;
      for (int i = 0; i < NREG; i++) dcnt[i] = 0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (!hold_mask[i] && (reg_req[i] != reg_ack[i])) begin
          if (dcnt[i] >= ack_lat) begin
            reg_ack[i] <= reg_req[i];
            dcnt[i] = 0;
          end else begin
            dcnt[i]++;
          end
        end else begin
          dcnt[i] = 0;
        end
      end
    end
  end

  // Behavioural model state.
  bit              m_ready = 0;
  bit              m_busy;
  logic [NREG-1:0] m_pend, m_req, m_we;
  int              m_waited;
  logic [AW-1:0]   m_wr_addr;
  bit              m_addr_known;
  logic [15:0]     m_wr_data;
  logic [1:0]      m_wr_be;
  bit              m_err;
  logic [7:0]      m_mod;
  logic [7:0]      m_dip[DIP_BYTES];
  bit              m_loaded, m_prev_dl, m_core_reset;
  int              m_since;

  // Model update: what each rule says must be true after this clock edge.
  always @(posedge clk_sys) begin
    bit          rom_wr, rom_dl, cause;
    int unsigned a;
    if (reset) begin
      m_ready = 1; m_busy = 0; m_pend = '0; m_req = '0; m_we = '0; m_waited = 0;
      m_wr_addr = '0; m_addr_known = 1; m_wr_data = '0; m_wr_be = '0; m_err = 0; m_mod = '0;
      for (int k = 0; k < DIP_BYTES; k++) m_dip[k] = 8'h00;
      m_loaded = 0; m_prev_dl = 0; m_core_reset = 1; m_since = 0;
    end else begin
      a      = 32'(ioctl_addr);
      rom_dl = ioctl_download && (ioctl_index == 8'd0);
      rom_wr = ioctl_wr && rom_dl;
      m_we   = '0;
      if (!m_busy) begin
        if (rom_wr) begin
          m_pend = '0;
          m_addr_known = 0;
          for (int i = 0; i < NREG; i++) begin
            if (a >= win_lo[i] && a <= win_hi[i]) begin
              m_wr_addr = AW'(a - win_lo[i]);
              m_addr_known = 1;
              if (win_noack[i]) m_we[i] = 1'b1;
              else begin m_req[i] = ~m_req[i]; m_pend[i] = 1'b1; end
            end
          end
          m_wr_data = {ioctl_dout, ioctl_dout};
          m_wr_be   = a[0] ? 2'b10 : 2'b01;
          if (m_pend != '0) begin m_busy = 1; m_waited = 0; end
        end
      end else begin
        if (rom_wr) m_err = 1;
        for (int i = 0; i < NREG; i++) if (m_pend[i] && reg_ack[i] == m_req[i]) m_pend[i] = 1'b0;
        if (m_pend == '0) m_busy = 0;
        else if (m_waited == ACK_TIMEOUT) begin m_err = 1; m_pend = '0; m_busy = 0; end
        else m_waited++;
      end
      if (ioctl_wr && ioctl_download && ioctl_index == 8'd1) m_mod = ioctl_dout;
      if (ioctl_wr && ioctl_download && ioctl_index == 8'd254 && a < DIP_BYTES) m_dip[a] = ioctl_dout;
      cause = user_reset || !m_loaded || rom_dl;
      m_core_reset = (m_since < int'(RST_CYCLES));
      if (m_prev_dl && !rom_dl) m_loaded = 1;
      m_prev_dl = rom_dl;
      if (cause) m_since = 0;
      else if (m_since < 1000000) m_since++;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: DUT against model on every falling edge once reset has been seen.
  always @(negedge clk_sys) begin
    logic [63:0] exp_dip;
    if (m_ready) begin
      exp_dip = '0;
      for (int k = 0; k < DIP_BYTES; k++) exp_dip[8*k +: 8] = m_dip[k];
      checkOutput("model_wait", 64'(ioctl_wait), 64'(m_busy && ((m_pend & (reg_ack ^ m_req)) != '0)));
      checkOutput("model_req", 64'(reg_req), 64'(m_req));
      checkOutput("model_we", 64'(reg_we), 64'(m_we));
      checkOutput("model_wr_data", 64'(wr_data), 64'(m_wr_data));
      checkOutput("model_wr_be", 64'(wr_be), 64'(m_wr_be));
      if (m_addr_known) checkOutput("model_wr_addr", 64'(wr_addr), 64'(m_wr_addr));
      checkOutput("model_dl_err", 64'(dl_err), 64'(m_err));
      checkOutput("model_core_mod", 64'(core_mod), 64'(m_mod));
      checkOutput("model_dip_sw", 64'(dip_sw), exp_dip);
      checkOutput("model_rom_loaded", 64'(rom_loaded), 64'(m_loaded));
      checkOutput("model_core_reset", 64'(core_reset), 64'(m_core_reset));
    end
  end

  task automatic applyStimulus(input bit dl, input logic [7:0] idx, input bit wr,
                               input logic [AW-1:0] addr, input logic [7:0] dout, input bit ures);
    ioctl_download = dl;
    ioctl_index    = idx;
    ioctl_wr       = wr;
    ioctl_addr     = addr;
    ioctl_dout     = dout;
    user_reset     = ures;
    @(posedge clk_sys);
    #1;
    ioctl_wr   = 1'b0;
    user_reset = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(ioctl_download, ioctl_index, 1'b0, ioctl_addr, ioctl_dout, 1'b0);
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    idleCycles(1);
    reset = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int k;
    pulseReset();
    pulseReset();
    $display("[TB] reset values");
    checkOutput("rst_core_reset", 64'(core_reset), 64'd1);
    checkOutput("rst_wait", 64'(ioctl_wait), 64'd0);
    checkOutput("rst_req", 64'(reg_req), 64'd0);
    checkOutput("rst_dl_err", 64'(dl_err), 64'd0);
    checkOutput("rst_rom_loaded", 64'(rom_loaded), 64'd0);
    checkOutput("rst_dip_sw", 64'(dip_sw), 64'd0);

    $display("[TB] overlapping handshake windows");
    hold_mask = 4'b0011;
    ack_lat   = 0;
    applyStimulus(1'b1, 8'd0, 1'b1, 25'h30001, 8'hA5, 1'b0);
    checkOutput("ovl_req", 64'(reg_req), 64'h3);
    checkOutput("ovl_be", 64'(wr_be), 64'h2);
    checkOutput("ovl_data", 64'(wr_data), 64'hA5A5);
    checkOutput("ovl_addr", 64'(wr_addr), 64'h1);
    checkOutput("ovl_wait", 64'(ioctl_wait), 64'd1);
    hold_mask = 4'b0010;
    idleCycles(4);
    checkOutput("ovl_wait_one_ack", 64'(ioctl_wait), 64'd1);
    hold_mask = 4'b0000;
    n = 0;
    while (ioctl_wait && n < 10) begin idleCycles(1); n++; end
    checkOutput("ovl_wait_release", 64'(ioctl_wait), 64'd0);
    idleCycles(2);

    $display("[TB] BRAM window");
    applyStimulus(1'b1, 8'd0, 1'b1, 25'h20010, 8'h3C, 1'b0);
    checkOutput("noack_we", 64'(reg_we), 64'h4);
    checkOutput("noack_wait", 64'(ioctl_wait), 64'd0);
    checkOutput("noack_req", 64'(reg_req), 64'h3);
    checkOutput("noack_addr", 64'(wr_addr), 64'h10);
    idleCycles(1);
    checkOutput("noack_we_end", 64'(reg_we), 64'h0);

    $display("[TB] mixed and missing windows");
    applyStimulus(1'b1, 8'd0, 1'b1, 25'h85000, 8'h77, 1'b0);
    checkOutput("mix_we", 64'(reg_we), 64'h8);
    checkOutput("mix_req", 64'(reg_req), 64'h1);
    checkOutput("mix_addr", 64'(wr_addr), 64'h5000);
    n = 0;
    while (ioctl_wait && n < 10) begin idleCycles(1); n++; end
    checkOutput("mix_wait_release", 64'(ioctl_wait), 64'd0);
    applyStimulus(1'b1, 8'd0, 1'b1, 25'h95000, 8'h11, 1'b0);
    checkOutput("miss_wait", 64'(ioctl_wait), 64'd0);
    checkOutput("miss_req", 64'(reg_req), 64'h1);

    $display("[TB] ack timeout");
    hold_mask = 4'b1111;
    applyStimulus(1'b1, 8'd0, 1'b1, 25'h30001, 8'h42, 1'b0);
    n = ioctl_wait ? 1 : 0;
    for (int i = 0; i < 25; i++) begin idleCycles(1); if (ioctl_wait) n++; end
    checkOutput("timeout_wait_cycles", 64'(n), 64'd16);
    checkOutput("timeout_dl_err", 64'(dl_err), 64'd1);

    $display("[TB] reset during wait");
    applyStimulus(1'b1, 8'd0, 1'b1, 25'h30001, 8'h43, 1'b0);
    idleCycles(2);
    pulseReset();
    checkOutput("rstwait_wait", 64'(ioctl_wait), 64'd0);
    checkOutput("rstwait_req", 64'(reg_req), 64'd0);
    checkOutput("rstwait_core_reset", 64'(core_reset), 64'd1);
    checkOutput("rstwait_dl_err", 64'(dl_err), 64'd0);
    hold_mask = 4'b0000;

    $display("[TB] DIP and core_mod capture");
    for (int a = 0; a < 10; a++) applyStimulus(1'b1, 8'd254, 1'b1, AW'(a), 8'(8'h10 + a), 1'b0);
    checkOutput("dip_sw", 64'(dip_sw), 64'h1716151413121110);
    applyStimulus(1'b1, 8'd1, 1'b1, 25'h0, 8'h5A, 1'b0);
    checkOutput("core_mod", 64'(core_mod), 64'h5A);
    applyStimulus(1'b0, 8'd0, 1'b0, 25'h0, 8'h00, 1'b0);

    $display("[TB] reset sequencer");
    pulseReset();
    checkOutput("seq_not_loaded", 64'(rom_loaded), 64'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'd0, 1'b0, 25'h0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 25'h0, 8'h00, 1'b0);
    checkOutput("seq_loaded", 64'(rom_loaded), 64'd1);
    n = 0; k = 0;
    while (core_reset && k < 40) begin n++; idleCycles(1); k++; end
    checkOutput("seq_hold_cycles", 64'(n), 64'd17);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 8'd0, 1'b0, 25'h0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 25'h0, 8'h00, 1'b0);
    idleCycles(5);
    applyStimulus(1'b0, 8'd0, 1'b0, 25'h0, 8'h00, 1'b1);
    n = 0; k = 0;
    while (core_reset && k < 40) begin n++; idleCycles(1); k++; end
    checkOutput("seq_user_reset_cycles", 64'(n), 64'd17);
    idleCycles(3);
    checkOutput("seq_released", 64'(core_reset), 64'd0);
    applyStimulus(1'b1, 8'd0, 1'b0, 25'h0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'd0, 1'b0, 25'h0, 8'h00, 1'b0);
    checkOutput("seq_redownload", 64'(core_reset), 64'd1);
    applyStimulus(1'b0, 8'd0, 1'b0, 25'h0, 8'h00, 1'b0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 4000; c++) begin
      bit            dl, wr, ur;
      logic [7:0]    idx, d;
      logic [AW-1:0] addr;
      dl = ioctl_download;
      idx = ioctl_index;
      if ($urandom_range(0, 99) == 0) begin
        dl = ~dl;
        if (dl) begin
          case ($urandom_range(0, 4))
            0, 1:    idx = 8'd0;
            2:       idx = 8'd1;
            3:       idx = 8'd254;
            default: idx = 8'd7;
          endcase
        end
      end
      wr = 1'b0;
      addr = ioctl_addr;
      d = 8'($urandom);
      if (dl && $urandom_range(0, 2) == 0 && (!ioctl_wait || $urandom_range(0, 19) == 0)) begin
        wr = 1'b1;
        if (idx == 8'd254) addr = AW'($urandom_range(0, 11));
        else if ($urandom_range(0, 1) == 0) addr = bounds[$urandom_range(0, 11)];
        else addr = AW'($urandom_range(0, 32'hFFFFF));
      end
      ur = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) begin
        hold_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
        ack_lat   = $urandom_range(0, 4);
      end
      if ($urandom_range(0, 999) == 0) reset = 1'b1;
      applyStimulus(dl, idx, wr, addr, d, ur);
      reset = 1'b0;
    end
    idleCycles(2);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
